// File: rtl/aes_block_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the two-requester AES core arbiter: default block
// width and in-flight depth, requester id constants and the lock state type
// used to hold the core input stable under backpressure.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int BLOCK_W_DEF = 128;
  localparam int DEPTH_DEF   = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Which requester (if any) currently owns the stalled core input.
  typedef enum logic [1:0] {
    LOCK_OPEN = 2'b00,
    LOCK_REQ0 = 2'b01,
    LOCK_REQ1 = 2'b10
  } lock_state_e;

  // Map a requester id onto the lock state that pins the grant to it.
  function automatic lock_state_e lock_for(input logic id);
    return (id == REQ1) ? LOCK_REQ1 : LOCK_REQ0;
  endfunction

endpackage

// File: rtl/aes_block_arbiter_if.sv
// -----------------------------------------------------------------------------
// aes_block_arbiter_if
// Bundles the requester-side, response-side and core-side valid/ready
// handshakes of the arbiter.
//   slave  : arbiter view (accepts requester blocks, drives the core input,
//            consumes core results, drives per-requester responses)
//   master : environment view (requesters, response sinks and the core)
// -----------------------------------------------------------------------------
interface aes_block_arbiter_if
  import aes_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEF
) ();

  logic               req0_valid;
  logic               req0_ready;
  logic [BLOCK_W-1:0] req0_block;
  logic               req1_valid;
  logic               req1_ready;
  logic [BLOCK_W-1:0] req1_block;

  logic               rsp0_valid;
  logic               rsp0_ready;
  logic [BLOCK_W-1:0] rsp0_block;
  logic               rsp1_valid;
  logic               rsp1_ready;
  logic [BLOCK_W-1:0] rsp1_block;

  logic               core_in_valid;
  logic               core_in_ready;
  logic [BLOCK_W-1:0] core_in_block;
  logic               core_out_valid;
  logic               core_out_ready;
  logic [BLOCK_W-1:0] core_out_block;

  modport slave (
    input  req0_valid, req0_block, req1_valid, req1_block,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_block, rsp1_valid, rsp1_block,
    input  rsp0_ready, rsp1_ready,
    output core_in_valid, core_in_block,
    input  core_in_ready,
    input  core_out_valid, core_out_block,
    output core_out_ready
  );

  modport master (
    output req0_valid, req0_block, req1_valid, req1_block,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_block, rsp1_valid, rsp1_block,
    output rsp0_ready, rsp1_ready,
    input  core_in_valid, core_in_block,
    output core_in_ready,
    output core_out_valid, core_out_block,
    input  core_out_ready
  );

endinterface

// File: rtl/aes_block_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// aes_tag_fifo
// Small synchronous FIFO recording which requester issued each block that is
// still inside the core.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push/push_data write one entry (ignored while full, even if popping)
//   pop            drop the head entry (ignored while empty)
//   head           oldest entry
//   count          number of stored entries
//   full, empty    occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module aes_tag_fifo #(
  parameter int  WIDTH = 1,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against occupancy; a pop never frees space for a same-cycle push.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == '0);

endmodule

// File: rtl/aes_block_arbiter.sv
// -----------------------------------------------------------------------------
// aes_block_arbiter
// Shares one block cipher core between two requester channels. Core input is
// granted round-robin (with a lock that keeps a stalled block stable), each
// issued block's requester id is queued in a tag FIFO, and in-order core
// results are steered back to the requester at the FIFO head.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          requester, response and core handshakes (slave modport)
//   outstanding  blocks issued to the core but not yet returned
//   idle         nothing outstanding and no requester offering a block
//   err          sticky: a core result arrived with nothing outstanding
// All handshake valid/ready outputs are forced low while rst_n is low.
// -----------------------------------------------------------------------------
module aes_block_arbiter
  import aes_pkg::*;
#(
  parameter int  BLOCK_W = BLOCK_W_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_block_arbiter_if.slave bus,
  output logic [CNT_W-1:0]   outstanding,
  output logic               idle,
  output logic               err
);

  lock_state_e        lock_state_r;
  lock_state_e        lock_state_s;
  logic               prio_r;
  logic               err_r;
  logic               grant_s;
  logic               reqg_valid_s;
  logic [BLOCK_W-1:0] reqg_block_s;
  logic               issue_s;
  logic               retire_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               head_s;
  logic [CNT_W-1:0]   count_s;

  // Grant: a held lock wins, otherwise the lone valid requester, otherwise prio.
  always_comb begin
    grant_s = REQ0;
    case (lock_state_r)
      LOCK_REQ0: grant_s = REQ0;
      LOCK_REQ1: grant_s = REQ1;
      LOCK_OPEN: begin
        if (bus.req0_valid && bus.req1_valid) begin
          grant_s = prio_r;
        end else if (bus.req1_valid) begin
          grant_s = REQ1;
        end else begin
          grant_s = REQ0;
        end
      end
      default: grant_s = REQ0;
    endcase
  end

  // Issue path: mux the granted requester onto the core input, blocked when full.
  always_comb begin
    reqg_valid_s = bus.req0_valid;
    reqg_block_s = bus.req0_block;
    if (grant_s == REQ1) begin
      reqg_valid_s = bus.req1_valid;
      reqg_block_s = bus.req1_block;
    end else begin
      reqg_valid_s = bus.req0_valid;
      reqg_block_s = bus.req0_block;
    end
    bus.core_in_valid = rst_n & reqg_valid_s & ~fifo_full_s;
    bus.core_in_block = reqg_block_s;
    bus.req0_ready    = rst_n & (grant_s == REQ0) & bus.core_in_ready & ~fifo_full_s;
    bus.req1_ready    = rst_n & (grant_s == REQ1) & bus.core_in_ready & ~fifo_full_s;
  end

  assign issue_s = bus.core_in_valid & bus.core_in_ready;

  // Lock next state: pin the grant while the core stalls an offered block.
  always_comb begin
    lock_state_s = lock_state_r;
    case (lock_state_r)
      LOCK_OPEN, LOCK_REQ0, LOCK_REQ1: begin
        if (issue_s) begin
          lock_state_s = LOCK_OPEN;
        end else if (bus.core_in_valid) begin
          lock_state_s = lock_for(grant_s);
        end else begin
          lock_state_s = lock_state_r;
        end
      end
      default: lock_state_s = LOCK_OPEN;
    endcase
  end

  // Return path: only the requester at the tag FIFO head sees the result.
  always_comb begin
    bus.rsp0_valid = rst_n & bus.core_out_valid & ~fifo_empty_s & (head_s == REQ0);
    bus.rsp1_valid = rst_n & bus.core_out_valid & ~fifo_empty_s & (head_s == REQ1);
    if (head_s == REQ1) begin
      bus.core_out_ready = rst_n & bus.rsp1_ready & ~fifo_empty_s;
    end else begin
      bus.core_out_ready = rst_n & bus.rsp0_ready & ~fifo_empty_s;
    end
    bus.rsp0_block = bus.core_out_block;
    bus.rsp1_block = bus.core_out_block;
  end

  assign retire_s = bus.core_out_valid & bus.core_out_ready;

  // Lock, round-robin priority and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state_r <= LOCK_OPEN;
      prio_r       <= REQ0;
      err_r        <= 1'b0;
    end else begin
      lock_state_r <= lock_state_s;
      if (issue_s) begin
        // The loser of this grant is favoured next time.
        prio_r <= ~grant_s;
      end
      if (bus.core_out_valid && fifo_empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  aes_tag_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue_s),
    .push_data (grant_s),
    .pop       (retire_s),
    .head      (head_s),
    .count     (count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign outstanding = count_s;
  assign idle        = (count_s == '0) & ~bus.req0_valid & ~bus.req1_valid;
  assign err         = err_r;

endmodule

// File: tb/tb_aes_block_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_block_arbiter
// Randomized bench: requesters, response sinks and an in-order core with
// variable latency are modelled here; a reference model of the arbitration
// rules (round-robin, lock under backpressure, depth limit, in-order return)
// predicts every handshake output each cycle.
// -----------------------------------------------------------------------------
module tb_aes_block_arbiter;
  import aes_pkg::*;

  localparam int BW    = 128;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [127:0] KEY = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] outstanding;
  logic             idle;
  logic             err;

  aes_block_arbiter_if #(.BLOCK_W(BW)) bus ();

  aes_block_arbiter #(.BLOCK_W(BW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .outstanding (outstanding),
    .idle        (idle),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus knobs (percent probabilities)
  int p_req [2];
  int p_rsp [2];
  int p_cir;
  bit ret_en;
  int lat_min, lat_max;
  bit spur_req;

  // Environment and reference model state
  bit            vld [2];
  logic [127:0]  cur_blk [2];
  int            seq = 0;
  int            cyc = 0;
  int            last_t = 0;
  logic [127:0]  pipe_q [$];
  int            pipe_t [$];
  bit            cov;
  logic [127:0]  cov_blk;
  bit            exp_tags [$];
  logic [127:0]  sb0 [$];
  logic [127:0]  sb1 [$];
  bit            m_prio, lock_on, lock_id, exp_err;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present requester blocks, core results and ready signals for this cycle.
  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!vld[i] && ($urandom_range(99) < p_req[i])) begin
        vld[i] = 1'b1;
        seq++;
        cur_blk[i] = {32'(i + 1), 32'(seq), $urandom, $urandom};
      end
    end
    if (!cov && ret_en && pipe_q.size() > 0 && pipe_t[0] <= cyc) begin
      cov     = 1'b1;
      cov_blk = pipe_q[0] ^ KEY;
    end
    if (spur_req && !cov && exp_tags.size() == 0) begin
      cov      = 1'b1;
      cov_blk  = {$urandom, $urandom, $urandom, $urandom};
      spur_req = 1'b0;
    end
    bus.req0_valid     = vld[0];
    bus.req0_block     = cur_blk[0];
    bus.req1_valid     = vld[1];
    bus.req1_block     = cur_blk[1];
    bus.core_in_ready  = ($urandom_range(99) < p_cir);
    bus.rsp0_ready     = ($urandom_range(99) < p_rsp[0]);
    bus.rsp1_ready     = ($urandom_range(99) < p_rsp[1]);
    bus.core_out_valid = cov;
    bus.core_out_block = cov_blk;
  endtask

  // Predict outputs from the arbitration rules, compare, then advance the model.
  task automatic observe();
    int n, t;
    bit full, ne, head, g, in_val, in_acc, cor, out_acc;
    logic [127:0] exp_blk;
    n    = exp_tags.size();
    full = (n == DEPTH);
    ne   = (n != 0);
    head = ne ? exp_tags[0] : 1'b0;
    if (lock_on) g = lock_id;
    else if (vld[0] && vld[1]) g = m_prio;
    else g = vld[1];
    in_val = vld[g] && !full;
    check_val("outstanding", 128'(outstanding), 128'(n));
    check_val("idle", 128'(idle), 128'(!ne && !vld[0] && !vld[1]));
    check_val("err", 128'(err), 128'(exp_err));
    check_val("core_in_valid", 128'(bus.core_in_valid), 128'(in_val));
    if (in_val) check_val("core_in_block", bus.core_in_block, cur_blk[g]);
    check_val("req0_ready", 128'(bus.req0_ready), 128'(!g && bus.core_in_ready && !full));
    check_val("req1_ready", 128'(bus.req1_ready), 128'(g && bus.core_in_ready && !full));
    cor = ne && (head ? bus.rsp1_ready : bus.rsp0_ready);
    check_val("rsp0_valid", 128'(bus.rsp0_valid), 128'(cov && ne && !head));
    check_val("rsp1_valid", 128'(bus.rsp1_valid), 128'(cov && ne && head));
    check_val("core_out_ready", 128'(bus.core_out_ready), 128'(cor));
    in_acc  = in_val && bus.core_in_ready;
    out_acc = cov && cor;
    if (out_acc) begin
      if (!head) begin
        exp_blk = sb0.pop_front();
        check_val("rsp0_block", bus.rsp0_block, exp_blk);
      end else begin
        exp_blk = sb1.pop_front();
        check_val("rsp1_block", bus.rsp1_block, exp_blk);
      end
      void'(exp_tags.pop_front());
      void'(pipe_q.pop_front());
      void'(pipe_t.pop_front());
      cov = 1'b0;
    end else if (cov && !ne) begin
      exp_err = 1'b1;
      cov     = 1'b0;
    end
    if (in_acc) begin
      exp_tags.push_back(g);
      pipe_q.push_back(cur_blk[g]);
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (t < last_t) t = last_t;
      last_t = t;
      pipe_t.push_back(t);
      if (!g) sb0.push_back(cur_blk[g] ^ KEY);
      else    sb1.push_back(cur_blk[g] ^ KEY);
      vld[g]  = 1'b0;
      m_prio  = ~g;
      lock_on = 1'b0;
    end else if (in_val) begin
      lock_on = 1'b1;
      lock_id = g;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_knobs(input int rq0, input int rq1, input int cir,
                           input int rs0, input int rs1, input bit ret);
    p_req[0] = rq0; p_req[1] = rq1; p_cir = cir;
    p_rsp[0] = rs0; p_rsp[1] = rs1; ret_en = ret;
  endtask

  task automatic clear_model();
    exp_tags.delete(); sb0.delete(); sb1.delete();
    pipe_q.delete(); pipe_t.delete();
    cov = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0;
    lock_on = 1'b0; lock_id = 1'b0; m_prio = 1'b0; exp_err = 1'b0;
    last_t = 0; spur_req = 1'b0;
  endtask

  // Assert reset mid-cycle and check outputs drop without any clock edge.
  task automatic do_reset_mid();
    #1;
    bus.core_out_valid = 1'b1;
    bus.rsp0_ready     = 1'b1;
    bus.rsp1_ready     = 1'b1;
    bus.core_in_ready  = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("rst_core_in_valid", 128'(bus.core_in_valid), 128'd0);
    check_val("rst_req0_ready", 128'(bus.req0_ready), 128'd0);
    check_val("rst_req1_ready", 128'(bus.req1_ready), 128'd0);
    check_val("rst_core_out_ready", 128'(bus.core_out_ready), 128'd0);
    check_val("rst_rsp0_valid", 128'(bus.rsp0_valid), 128'd0);
    check_val("rst_rsp1_valid", 128'(bus.rsp1_valid), 128'd0);
    check_val("rst_outstanding", 128'(outstanding), 128'd0);
    check_val("rst_err", 128'(err), 128'd0);
    clear_model();
    bus.req0_valid     = 1'b0;
    bus.req1_valid     = 1'b0;
    bus.core_out_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clear_model();
    lat_min = 2; lat_max = 2;
    set_knobs(0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_block = '0;
    bus.req1_valid = 1'b0; bus.req1_block = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.core_in_ready = 1'b0;
    bus.core_out_valid = 1'b0; bus.core_out_block = '0;
    #12;
    check_val("reset_outstanding", 128'(outstanding), 128'd0);
    check_val("reset_core_in_valid", 128'(bus.core_in_valid), 128'd0);
    check_val("reset_err", 128'(err), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(2);

    // Both requesters valid, core always ready, fixed 2-cycle latency
    set_knobs(100, 100, 100, 100, 100, 1'b1);
    run(20);
    set_knobs(0, 0, 100, 100, 100, 1'b1);
    run(10);

    // Core input backpressure on a lone req1 block, then req0 joins
    set_knobs(0, 100, 0, 100, 100, 1'b1);
    run(3);
    set_knobs(100, 100, 100, 100, 100, 1'b1);
    run(4);
    set_knobs(0, 0, 100, 100, 100, 1'b1);
    run(10);

    // Fill to depth with the core holding results, then release one at a time
    set_knobs(100, 100, 100, 100, 100, 1'b0);
    run(8);
    check_val("full_outstanding", 128'(outstanding), 128'(DEPTH));
    check_val("full_ready", 128'(bus.req0_ready | bus.req1_ready), 128'd0);
    set_knobs(0, 0, 100, 100, 100, 1'b1);
    run(12);

    // Response backpressure on requester 1 only
    lat_min = 1; lat_max = 3;
    set_knobs(60, 60, 80, 100, 0, 1'b1);
    run(30);
    set_knobs(0, 0, 80, 100, 100, 1'b1);
    run(20);

    // Spurious core result with nothing outstanding
    spur_req = 1'b1;
    run(6);
    check_val("err_sticky", 128'(err), 128'd1);

    // Reset with three blocks in flight
    set_knobs(100, 100, 100, 100, 100, 1'b0);
    run(3);
    check_val("pre_reset_outstanding", 128'(outstanding), 128'd3);
    do_reset_mid();
    set_knobs(0, 0, 100, 100, 100, 1'b1);
    run(2);
    set_knobs(100, 100, 100, 100, 100, 1'b1);
    run(6);

    // Randomized traffic with varying knobs
    for (int blk = 0; blk < 60; blk++) begin
      lat_max = int'($urandom_range(6, 1));
      lat_min = int'($urandom_range(lat_max, 1));
      set_knobs(int'($urandom_range(100)), int'($urandom_range(100)),
                int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
                int'($urandom_range(100, 20)), ($urandom_range(9) != 0));
      run(40);
    end
    set_knobs(0, 0, 100, 100, 100, 1'b1);
    run(40);
    check_val("final_outstanding", 128'(outstanding), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_block_arbiter.md
Name: aes_block_arbiter

Overview:
- Shares one 128-bit block cipher core between two requester channels. Each requester channel is a block builder/splitter pair.
- Grants core input round-robin and records which requester issued each block in a tag FIFO. Core results are routed back to the originating requester, in order.
- Sits between the per-channel block adapters and the single AES core instance.

Parameters:
- BLOCK_W, 128, block data width.
- DEPTH, 4, max blocks in flight inside the core (tag FIFO depth, power of two, >=2).
- CNT_W, $clog2(DEPTH+1), width of the outstanding counter (derived, not overridden).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 block offered to core.
- req0_ready  out  1  requester 0 block accepted.
- req0_block  in  BLOCK_W  requester 0 block data.
- req1_valid / req1_ready / req1_block  same, requester 1.
- rsp0_valid  out  1  result block for requester 0.
- rsp0_ready  in  1  requester 0 accepts result.
- rsp0_block  out  BLOCK_W  result data (core_out_block fan-out).
- rsp1_valid / rsp1_ready / rsp1_block  same, requester 1.
- core_in_valid  out  1  block to core.
- core_in_ready  in  1  core accepts block.
- core_in_block  out  BLOCK_W  muxed requester block.
- core_out_valid  in  1  core result available; core returns results strictly in issue order.
- core_out_ready  out  1  result consumed.
- core_out_block  in  BLOCK_W  core result.
- outstanding  out  CNT_W  blocks issued but not yet returned.
- idle  out  1  outstanding==0 and no req valid.
- err  out  1  sticky: core_out_valid seen while outstanding==0.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Clears tag FIFO pointers, outstanding, prio (=0), lock, err.
  - All *_ready and *_valid outputs go to 0 combinationally. Data outputs are don't-care.
  - Blocks in flight in the core are abandoned. Any core_out_valid after reset is flagged as err.
- Handshake: a transfer occurs on a cycle with valid&ready high at the rising edge. Producers hold valid and data until accepted.
- Grant (combinational, zero added latency):
  - Only req0 valid -> g=0. Only req1 valid -> g=1. Both -> g=prio.
  - If lock is set, g=lock_id regardless of the rule above.
- Issue path, with full = (outstanding==DEPTH):
  - core_in_valid = reqg_valid & ~full.
  - core_in_block = reqg_block.
  - reqg_ready = core_in_ready & ~full.
  - Non-granted req_ready = 0.
- Lock: set to g when core_in_valid & ~core_in_ready; cleared on accept. Guarantees core_in_valid/data stability under core backpressure.
- prio: on each core_in accept, prio <= ~g (loser of the last grant gets priority next).
- Tag FIFO:
  - Push g on core_in accept; pop on core_out accept.
  - When full, push is blocked even if a pop happens the same cycle; no ready-through path.
  - Simultaneous push and pop when not full: outstanding unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Return path, with h = FIFO head and ne = (outstanding!=0):
  - rsph_valid = core_out_valid & ne. Other rsp_valid = 0.
  - core_out_ready = rsph_ready & ne.
  - rsp0_block = rsp1_block = core_out_block.
- Empty with core_out_valid high: core_out_ready=0 and err <= 1. err stays set until reset.
- Throughput: 1 block/cycle issue and 1 block/cycle return when not full or empty.

Decomposition:
- Shared package (aes_pkg): BLOCK_W default, requester id constants REQ0=1'b0 and REQ1=1'b1, DEPTH default.
- One sub-module: aes_tag_fifo. Parameterized width-1 synchronous FIFO with push, pop, head, count, full and empty outputs, async active-low reset. The arbiter owns grant, lock, prio and routing.

Test Plan:
- Alternating grant: both reqs valid continuously, core always ready, DEPTH=4, core returns after 2 cycles. Issue order must be 0,1,0,1… and rsp0/rsp1 receive their own blocks (req0 data 0x00…01, req1 data 0x00…02) in order.
- Core backpressure: req1 valid alone, core_in_ready low for 3 cycles, then req0 asserts. core_in_block must stay req1's block until accept, and the next grant goes to req0.
- Full: core never returns, 6 blocks offered. Exactly 4 accepted, outstanding=4, req ready=0. One core_out accept then allows a 5th issue the cycle after (not the same cycle).
- Response backpressure: head tag=1, rsp1_ready low for 5 cycles while rsp0_ready high. core_out_ready=0 and rsp0_valid=0 throughout, and no reorder occurs.
- Spurious result: outstanding=0, core_out_valid pulses. err=1 and stays 1, core_out_ready=0, and both rsp_valid stay 0.
- Reset mid-operation: 3 blocks outstanding, rst_n low asynchronously mid-cycle. Outputs go to 0 without waiting for a clock edge; after release outstanding=0, idle=1, prio=0.
